// File: rtl/lsu_bytelane_if.sv
// Request/response bus between the core's MEM stage and the load/store unit.
// Signal names keep the unit's point of view: i_* flow into the LSU, o_* flow out.
interface lsu_bytelane_if;
    logic        i_req;
    logic        o_ready;
    logic        i_wren;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [31:0] i_wdata;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_misalign;

    modport master (
        output i_req, i_wren, i_addr, i_size, i_unsigned, i_wdata,
        input  o_ready, o_rvalid, o_rdata, o_misalign
    );

    modport slave (
        input  i_req, i_wren, i_addr, i_size, i_unsigned, i_wdata,
        output o_ready, o_rvalid, o_rdata, o_misalign
    );
endinterface

// File: rtl/lsu_bytelane.sv
// RV32I load/store unit: byte/half/word access to a registered data memory plus
// memory-mapped LED/HEX/LCD output registers and a synchronised switch input.
module lsu_bytelane #(
    parameter int unsigned DMEM_DEPTH = 512,
    parameter int unsigned NUM_HEX    = 8,
    parameter int unsigned LEDR_W     = 32,
    parameter int unsigned LEDG_W     = 32,
    parameter int unsigned SW_W       = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    lsu_bytelane_if.slave        bus,
    output logic [LEDR_W-1:0]    o_io_ledr,
    output logic [LEDG_W-1:0]    o_io_ledg,
    output logic [NUM_HEX*7-1:0] o_io_hex,
    output logic [31:0]          o_io_lcd,
    input  logic [SW_W-1:0]      i_io_sw
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StResp = 1'b1;

    localparam logic [19:0] PageLedr = 20'h10000;
    localparam logic [19:0] PageLedg = 20'h10001;
    localparam logic [19:0] PageHex0 = 20'h10002;
    localparam logic [19:0] PageHex4 = 20'h10003;
    localparam logic [19:0] PageLcd  = 20'h10004;
    localparam logic [19:0] PageSw   = 20'h10010;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  en);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = en[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    logic [0:0]  state_q, state_d;
    logic        accept;
    logic [31:0] addr;
    logic [19:0] page;
    logic [AW-1:0] widx;
    logic        hit_dmem, hit_ledr, hit_ledg, hit_hex0, hit_hex4, hit_lcd, hit_sw;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic        wr_ok, rd_ok;

    assign addr   = bus.i_addr;
    assign page   = addr[31:12];
    assign widx   = addr[AW+1:2];
    assign accept = bus.i_req && (state_q == StIdle) && !i_reset;

    assign hit_dmem = (addr[31:AW+2] == '0);
    assign hit_ledr = (page == PageLedr);
    assign hit_ledg = (page == PageLedg);
    assign hit_hex0 = (page == PageHex0);
    assign hit_hex4 = (page == PageHex4);
    assign hit_lcd  = (page == PageLcd);
    assign hit_sw   = (page == PageSw);

    always_comb begin
        mis  = 1'b0;
        be   = 4'b0000;
        wrep = bus.i_wdata;
        unique case (bus.i_size)
            2'b00: begin
                be   = 4'b0001 << addr[1:0];
                wrep = {4{bus.i_wdata[7:0]}};
            end
            2'b01: begin
                mis  = addr[0];
                be   = addr[1] ? 4'b1100 : 4'b0011;
                wrep = {2{bus.i_wdata[15:0]}};
            end
            2'b10: begin
                mis = |addr[1:0];
                be  = 4'b1111;
            end
            default: begin
                mis = 1'b1;
            end
        endcase
    end

    assign wr_ok = accept && bus.i_wren && !mis;
    assign rd_ok = accept && !bus.i_wren && !mis;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StResp;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= StIdle;
        else         state_q <= state_d;
    end

    // Data memory: no reset so it maps onto block RAM with byte enables.
    logic [31:0] mem_q [DMEM_DEPTH];
    logic [31:0] rword_q;

    always_ff @(posedge i_clk) begin
        if (wr_ok && hit_dmem) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[widx][8*b +: 8] <= wrep[8*b +: 8];
            end
        end
        if (rd_ok && hit_dmem) rword_q <= mem_q[widx];
    end

    // Output registers.
    logic [LEDR_W-1:0] ledr_q, ledr_d;
    logic [LEDG_W-1:0] ledg_q, ledg_d;
    logic [31:0]       lcd_q, lcd_d;
    logic [31:0]       ledr_m, ledg_m;
    logic [6:0]        hex_q [8];

    assign ledr_m = merge_bytes(32'(ledr_q), wrep, be);
    assign ledg_m = merge_bytes(32'(ledg_q), wrep, be);

    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        lcd_d  = lcd_q;
        if (wr_ok && hit_ledr) ledr_d = ledr_m[LEDR_W-1:0];
        if (wr_ok && hit_ledg) ledg_d = ledg_m[LEDG_W-1:0];
        if (wr_ok && hit_lcd)  lcd_d  = merge_bytes(lcd_q, wrep, be);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ledr_q <= '0;
            ledg_q <= '0;
            lcd_q  <= '0;
        end else begin
            ledr_q <= ledr_d;
            ledg_q <= ledg_d;
            lcd_q  <= lcd_d;
        end
    end

    // Digits beyond NUM_HEX are never written, so they stay at reset value and read 0.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < 8; k++) hex_q[k] <= '0;
        end else if (wr_ok) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n] && hit_hex0 && (n < NUM_HEX))     hex_q[n]     <= wrep[8*n +: 7];
                if (be[n] && hit_hex4 && (n + 4 < NUM_HEX)) hex_q[n + 4] <= wrep[8*n +: 7];
            end
        end
    end

    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex_out
        assign o_io_hex[7*k +: 7] = hex_q[k];
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;

    // Two-flop synchroniser for the asynchronous switch bank.
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= i_io_sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    logic [31:0] io_word;

    always_comb begin
        io_word = '0;
        if (hit_ledr) io_word = 32'(ledr_q);
        if (hit_ledg) io_word = 32'(ledg_q);
        if (hit_hex0) io_word = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
        if (hit_hex4) io_word = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
        if (hit_lcd)  io_word = lcd_q;
        if (hit_sw)   io_word = 32'(sw_sync_q);
    end

    // Response context captured on the accept edge.
    logic        wr_q, mis_q, uns_q, src_dmem_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] io_word_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q       <= 1'b0;
            mis_q      <= 1'b0;
            uns_q      <= 1'b0;
            src_dmem_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            io_word_q  <= '0;
        end else if (accept) begin
            wr_q       <= bus.i_wren;
            mis_q      <= mis;
            uns_q      <= bus.i_unsigned;
            src_dmem_q <= hit_dmem;
            size_q     <= bus.i_size;
            off_q      <= addr[1:0];
            io_word_q  <= rd_ok ? io_word : 32'd0;
        end
    end

    logic [31:0] rsp_word, rsp_ext;
    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    assign rsp_word = src_dmem_q ? rword_q : io_word_q;
    assign rsp_byte = rsp_word[{off_q, 3'b000} +: 8];
    assign rsp_half = off_q[1] ? rsp_word[31:16] : rsp_word[15:0];

    always_comb begin
        rsp_ext = '0;
        unique case (size_q)
            2'b00:   rsp_ext = uns_q ? {24'd0, rsp_byte} : {{24{rsp_byte[7]}}, rsp_byte};
            2'b01:   rsp_ext = uns_q ? {16'd0, rsp_half} : {{16{rsp_half[15]}}, rsp_half};
            2'b10:   rsp_ext = rsp_word;
            default: rsp_ext = '0;
        endcase
    end

    assign bus.o_ready    = (state_q == StIdle);
    assign bus.o_rvalid   = (state_q == StResp);
    assign bus.o_misalign = (state_q == StResp) && mis_q;
    assign bus.o_rdata    = ((state_q == StResp) && !wr_q && !mis_q) ? rsp_ext : 32'd0;

endmodule

// File: tb/tb_lsu_bytelane.sv
// Scoreboard bench for lsu_bytelane: each accepted access pushes its expected response,
// the negedge monitor pops and compares whenever o_rvalid pulses.
module tb_lsu_bytelane;

    localparam logic [1:0] SzB = 2'b00;
    localparam logic [1:0] SzH = 2'b01;
    localparam logic [1:0] SzW = 2'b10;
    localparam logic [1:0] SzX = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ledr, ledg, lcd;
    logic [55:0] hex;
    logic [31:0] sw;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    lsu_bytelane_if bus ();

    lsu_bytelane dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .bus       (bus),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_hex  (hex),
        .o_io_lcd  (lcd),
        .i_io_sw   (sw)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_rvalid) begin
            if (exp_q.size() == 0) begin
                check_eq("rv_unexpected", {31'd0, bus.o_rvalid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("rdata", bus.o_rdata, mon_e[31:0]);
                check_eq("misalign", {31'd0, bus.o_misalign}, {31'd0, mon_e[32]});
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                          input logic uns, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_mis);
        int n = 0;
        @(negedge clk);
        while (!bus.o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check_eq("ready_timeout", {31'd0, bus.o_ready}, 32'd1);
            return;
        end
        bus.i_req      = 1'b1;
        bus.i_wren     = wr;
        bus.i_addr     = a;
        bus.i_size     = sz;
        bus.i_unsigned = uns;
        bus.i_wdata    = wd;
        exp_q.push_back({exp_mis, exp_rd});
        @(posedge clk);
        #1 bus.i_req = 1'b0;
        @(negedge clk);
        check_eq("rv_latency", {31'd0, bus.o_rvalid}, 32'd1);
        check_eq("resp_ready", {31'd0, bus.o_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        sw  = 32'd0;
        bus.i_req = 1'b0; bus.i_wren = 1'b0; bus.i_addr = '0;
        bus.i_size = SzW; bus.i_unsigned = 1'b0; bus.i_wdata = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'd0, bus.o_ready}, 32'd1);
        check_eq("rst_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        check_eq("rst_rdata", bus.o_rdata, 32'd0);
        check_eq("rst_ledr", ledr, 32'd0);
        check_eq("rst_hex", {31'd0, |hex}, 32'd0);
        rst = 1'b0;

        // Word, byte and half accesses to data memory
        access(1, 32'h0000_0000, SzW, 0, 32'h0102_0304, 32'd0, 0);
        access(1, 32'h0000_0010, SzW, 0, 32'hDEAD_BEEF, 32'd0, 0);
        access(0, 32'h0000_0010, SzW, 0, 32'd0, 32'hDEAD_BEEF, 0);
        access(1, 32'h0000_0011, SzB, 0, 32'h0000_0080, 32'd0, 0);
        access(0, 32'h0000_0011, SzB, 0, 32'd0, 32'hFFFF_FF80, 0);
        access(0, 32'h0000_0011, SzB, 1, 32'd0, 32'h0000_0080, 0);
        access(0, 32'h0000_0010, SzW, 0, 32'd0, 32'hDEAD_80EF, 0);
        access(0, 32'h0000_0012, SzH, 0, 32'd0, 32'hFFFF_DEAD, 0);
        access(0, 32'h0000_0012, SzH, 1, 32'd0, 32'h0000_DEAD, 0);
        access(1, 32'h0000_0012, SzH, 0, 32'hAAAA_1234, 32'd0, 0);
        access(0, 32'h0000_0010, SzW, 0, 32'd0, 32'h1234_80EF, 0);

        // Misaligned and illegal-size accesses leave memory alone
        access(0, 32'h0000_0013, SzH, 0, 32'd0, 32'd0, 1);
        access(1, 32'h0000_0002, SzW, 0, 32'hFFFF_FFFF, 32'd0, 1);
        access(1, 32'h0000_0010, SzX, 0, 32'hFFFF_FFFF, 32'd0, 1);
        access(0, 32'h0000_0010, SzX, 0, 32'd0, 32'd0, 1);
        access(0, 32'h0000_0000, SzW, 0, 32'd0, 32'h0102_0304, 0);
        access(0, 32'h0000_0010, SzW, 0, 32'd0, 32'h1234_80EF, 0);

        // Top of data memory, then the first unmapped word above it
        access(1, 32'h0000_07FC, SzW, 0, 32'h55AA_55AA, 32'd0, 0);
        access(0, 32'h0000_07FC, SzW, 0, 32'd0, 32'h55AA_55AA, 0);
        access(1, 32'h0000_0800, SzW, 0, 32'hFFFF_FFFF, 32'd0, 0);
        access(0, 32'h0000_0800, SzW, 0, 32'd0, 32'd0, 0);
        access(0, 32'h0000_0000, SzW, 0, 32'd0, 32'h0102_0304, 0);
        access(0, 32'h2000_0000, SzW, 0, 32'd0, 32'd0, 0);

        // Seven-segment digits
        access(1, 32'h1000_2000, SzW, 0, 32'h7F3F_067F, 32'd0, 0);
        access(1, 32'h1000_3001, SzB, 0, 32'h0000_005B, 32'd0, 0);
        check_eq("hex0", {25'd0, hex[6:0]}, 32'h7F);
        check_eq("hex1", {25'd0, hex[13:7]}, 32'h06);
        check_eq("hex2", {25'd0, hex[20:14]}, 32'h3F);
        check_eq("hex3", {25'd0, hex[27:21]}, 32'h7F);
        check_eq("hex5", {25'd0, hex[41:35]}, 32'h5B);
        access(0, 32'h1000_2000, SzW, 0, 32'd0, 32'h7F3F_067F, 0);
        access(0, 32'h1000_3000, SzW, 0, 32'd0, 32'h0000_5B00, 0);
        access(1, 32'h1000_2000, SzB, 0, 32'h0000_0080, 32'd0, 0);
        access(0, 32'h1000_2000, SzW, 0, 32'd0, 32'h7F3F_0600, 0);

        // LED and LCD registers
        access(1, 32'h1000_0000, SzW, 0, 32'hA5A5_1234, 32'd0, 0);
        access(1, 32'h1000_0002, SzH, 0, 32'h0000_BEEF, 32'd0, 0);
        check_eq("ledr", ledr, 32'hBEEF_1234);
        access(0, 32'h1000_0002, SzH, 1, 32'd0, 32'h0000_BEEF, 0);
        access(0, 32'h1000_0002, SzH, 0, 32'd0, 32'hFFFF_BEEF, 0);
        access(1, 32'h1000_1003, SzB, 0, 32'h0000_003C, 32'd0, 0);
        check_eq("ledg", ledg, 32'h3C00_0000);
        access(0, 32'h1000_1003, SzB, 1, 32'd0, 32'h0000_003C, 0);
        access(1, 32'h1000_4000, SzW, 0, 32'hCAFE_F00D, 32'd0, 0);
        check_eq("lcd", lcd, 32'hCAFE_F00D);
        access(0, 32'h1000_4003, SzB, 0, 32'd0, 32'hFFFF_FFCA, 0);
        access(0, 32'h1000_4000, SzB, 0, 32'd0, 32'h0000_000D, 0);

        // Switches through the two-flop synchroniser
        sw = 32'h0000_00A5;
        repeat (3) @(negedge clk);
        access(0, 32'h1001_0000, SzW, 0, 32'd0, 32'h0000_00A5, 0);
        access(1, 32'h1001_0000, SzW, 0, 32'hFFFF_FFFF, 32'd0, 0);
        sw = 32'h0000_5A5A;
        access(0, 32'h1001_0000, SzW, 0, 32'd0, 32'h0000_00A5, 0);
        access(0, 32'h1001_0000, SzW, 0, 32'd0, 32'h0000_5A5A, 0);

        // Held request: ready alternates, requests in RESP are ignored
        @(negedge clk);
        bus.i_wren = 1'b0; bus.i_addr = 32'h1001_0000; bus.i_size = SzW; bus.i_unsigned = 1'b0;
        bus.i_req  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check_eq("hold_ready", {31'd0, bus.o_ready}, {31'd0, (i % 2) == 0});
            if (bus.o_ready) exp_q.push_back({1'b0, 32'h0000_5A5A});
        end
        bus.i_req = 1'b0;

        // Reset during RESP, then a store accepted on a reset edge
        access(0, 32'h0000_0010, SzW, 0, 32'd0, 32'h1234_80EF, 0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        check_eq("rstmid_ready", {31'd0, bus.o_ready}, 32'd1);
        check_eq("rstmid_ledr", ledr, 32'd0);
        check_eq("rstmid_ledg", ledg, 32'd0);
        check_eq("rstmid_lcd", lcd, 32'd0);
        check_eq("rstmid_hex", {31'd0, |hex}, 32'd0);
        bus.i_req = 1'b1; bus.i_wren = 1'b1; bus.i_addr = 32'h0000_0010;
        bus.i_size = SzW; bus.i_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        rst = 1'b0;
        bus.i_req = 1'b0;
        check_eq("rststore_rvalid", {31'd0, bus.o_rvalid}, 32'd0);
        access(0, 32'h0000_0010, SzW, 0, 32'd0, 32'h1234_80EF, 0);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
